// File: rtl/axi_rd_arbiter.sv
// Two-master read arbiter sharing one AXI AR/R channel pair between IFU and LSU.
// One outstanding single-beat read at a time. A watchdog aborts stalled transactions.
module axi_rd_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int PRIO_LSU    = 0,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ifu_AR_ADDR,
  input  logic              ifu_AR_VALID,
  output logic              ifu_AR_READY,
  output logic [DATA_W-1:0] ifu_R_DATA,
  output logic              ifu_R_VALID,
  input  logic              ifu_R_READY,
  input  logic [ADDR_W-1:0] lsu_AR_ADDR,
  input  logic              lsu_AR_VALID,
  output logic              lsu_AR_READY,
  output logic [DATA_W-1:0] lsu_R_DATA,
  output logic              lsu_R_VALID,
  input  logic              lsu_R_READY,
  input  logic              wr_pending,
  output logic [ADDR_W-1:0] axi_AR_ADDR,
  output logic              axi_AR_VALID,
  input  logic              axi_AR_READY,
  input  logic [DATA_W-1:0] axi_R_DATA,
  input  logic              axi_R_VALID,
  output logic              axi_R_READY,
  output logic [1:0]        rd_grant,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1'b1);
  localparam logic            WD_ON   = (TIMEOUT_CYC != 0);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;   // 1: LSU owned the last completed read
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_q, err_d;

  logic              req_ifu_s, req_lsu_s, ar_hs_s, r_hs_s, wd_fire_s;

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Arbitration, FSM sequencing and watchdog
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    req_ifu_s = ifu_AR_VALID;
    req_lsu_s = lsu_AR_VALID & ~wr_pending;
    ar_hs_s   = axi_AR_VALID & axi_AR_READY;
    r_hs_s    = axi_R_VALID & axi_R_READY;
    wd_fire_s = WD_ON & (wdog_q == WD_LAST);
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (req_ifu_s && req_lsu_s) begin
          state_d = ADDR;
          if (PRIO_LSU != 0) begin
            grant_d = 2'b10;
          end else if (last_q) begin
            grant_d = 2'b01;
          end else begin
            grant_d = 2'b10;
          end
        end else if (req_lsu_s) begin
          state_d = ADDR;
          grant_d = 2'b10;
        end else if (req_ifu_s) begin
          state_d = ADDR;
          grant_d = 2'b01;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (wd_fire_s) begin
          err_d   = 1'b1;
          grant_d = 2'b00;
          state_d = IDLE;
        end else begin
          wdog_d = WD_ON ? (wdog_q + WD_ONE) : wdog_q;
          if (ar_hs_s) begin
            state_d = DATA;
          end else begin
            state_d = ADDR;
          end
        end
      end
      DATA: begin
        // A completing beat wins over a watchdog expiry in the same cycle
        if (r_hs_s) begin
          state_d = IDLE;
          last_d  = grant_q[1];
          grant_d = 2'b00;
        end else if (wd_fire_s) begin
          err_d   = 1'b1;
          grant_d = 2'b00;
          state_d = IDLE;
        end else begin
          wdog_d = WD_ON ? (wdog_q + WD_ONE) : wdog_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Channel routing toward the current owner
  always_comb begin
    ifu_AR_READY = 1'b0;
    lsu_AR_READY = 1'b0;
    ifu_R_VALID  = 1'b0;
    lsu_R_VALID  = 1'b0;
    ifu_R_DATA   = '0;
    lsu_R_DATA   = '0;
    axi_AR_VALID = 1'b0;
    axi_AR_ADDR  = '0;
    axi_R_READY  = 1'b0;
    case (state_q)
      ADDR: begin
        if (grant_q[1]) begin
          axi_AR_VALID = lsu_AR_VALID;
          axi_AR_ADDR  = lsu_AR_ADDR;
          lsu_AR_READY = axi_AR_READY;
        end else if (grant_q[0]) begin
          axi_AR_VALID = ifu_AR_VALID;
          axi_AR_ADDR  = ifu_AR_ADDR;
          ifu_AR_READY = axi_AR_READY;
        end else begin
          axi_AR_VALID = 1'b0;
        end
      end
      DATA: begin
        ifu_R_DATA = axi_R_DATA;
        lsu_R_DATA = axi_R_DATA;
        if (grant_q[1]) begin
          lsu_R_VALID = axi_R_VALID;
          axi_R_READY = lsu_R_READY;
        end else if (grant_q[0]) begin
          ifu_R_VALID = axi_R_VALID;
          axi_R_READY = ifu_R_READY;
        end else begin
          axi_R_READY = 1'b0;
        end
      end
      default: begin
        axi_AR_VALID = 1'b0;
      end
    endcase
  end

  assign rd_grant    = grant_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: random requesters and slave, transaction-level model and data scoreboard.
// A second instance exercises fixed LSU priority with the watchdog disabled.
module tb_axi_rd_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] ifu_AR_ADDR, lsu_AR_ADDR, axi_AR_ADDR;
  logic          ifu_AR_VALID, ifu_AR_READY, ifu_R_VALID, ifu_R_READY;
  logic          lsu_AR_VALID, lsu_AR_READY, lsu_R_VALID, lsu_R_READY;
  logic [DW-1:0] ifu_R_DATA, lsu_R_DATA, axi_R_DATA;
  logic          wr_pending, axi_AR_VALID, axi_AR_READY, axi_R_VALID, axi_R_READY;
  logic [1:0]    rd_grant;
  logic          timeout_err;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_LSU(0), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_AR_ADDR(ifu_AR_ADDR), .ifu_AR_VALID(ifu_AR_VALID), .ifu_AR_READY(ifu_AR_READY),
    .ifu_R_DATA(ifu_R_DATA), .ifu_R_VALID(ifu_R_VALID), .ifu_R_READY(ifu_R_READY),
    .lsu_AR_ADDR(lsu_AR_ADDR), .lsu_AR_VALID(lsu_AR_VALID), .lsu_AR_READY(lsu_AR_READY),
    .lsu_R_DATA(lsu_R_DATA), .lsu_R_VALID(lsu_R_VALID), .lsu_R_READY(lsu_R_READY),
    .wr_pending(wr_pending),
    .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
    .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY),
    .rd_grant(rd_grant), .timeout_err(timeout_err)
  );

  // Fixed-priority instance, watchdog disabled
  logic          p_rst_n;
  logic [AW-1:0] p_ifu_a, p_lsu_a, p_axi_a;
  logic          p_ifu_v, p_ifu_ardy, p_ifu_rv, p_ifu_rr;
  logic          p_lsu_v, p_lsu_ardy, p_lsu_rv, p_lsu_rr;
  logic [DW-1:0] p_ifu_rd, p_lsu_rd, p_axi_rd;
  logic          p_wp, p_axi_v, p_axi_ardy, p_axi_rv, p_axi_rr;
  logic [1:0]    p_grant;
  logic          p_err;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_LSU(1), .TIMEOUT_CYC(0)) dut_p (
    .clk(clk), .rst_n(p_rst_n),
    .ifu_AR_ADDR(p_ifu_a), .ifu_AR_VALID(p_ifu_v), .ifu_AR_READY(p_ifu_ardy),
    .ifu_R_DATA(p_ifu_rd), .ifu_R_VALID(p_ifu_rv), .ifu_R_READY(p_ifu_rr),
    .lsu_AR_ADDR(p_lsu_a), .lsu_AR_VALID(p_lsu_v), .lsu_AR_READY(p_lsu_ardy),
    .lsu_R_DATA(p_lsu_rd), .lsu_R_VALID(p_lsu_rv), .lsu_R_READY(p_lsu_rr),
    .wr_pending(p_wp),
    .axi_AR_ADDR(p_axi_a), .axi_AR_VALID(p_axi_v), .axi_AR_READY(p_axi_ardy),
    .axi_R_DATA(p_axi_rd), .axi_R_VALID(p_axi_rv), .axi_R_READY(p_axi_rr),
    .rd_grant(p_grant), .timeout_err(p_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory contents seen by the slave model
  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0000_0413;
    return a ^ 64'h5A5A_F00D_1234_C0DE;
  endfunction

  // Knobs written by the sequencer
  int ifu_rate = 0, lsu_rate = 0, ifu_limit = 0, lsu_limit = 0;
  int wp_mode = 2;
  int fix_delay = -1;
  bit fast = 1'b0, mute = 1'b0, ifu_fix = 1'b0, mon_en = 1'b0, p_done = 1'b0;

  // Driver state
  int ifu_issued = 0, lsu_issued = 0;
  bit d_rs, d_ih, d_lh, d_ah, d_rh, d_pend;
  logic [63:0] d_a, d_paddr;
  int d_delay, d_arw, d_iw, d_lw;

  initial begin : driver
    ifu_AR_VALID = 1'b0; ifu_AR_ADDR = '0; ifu_R_READY = 1'b0;
    lsu_AR_VALID = 1'b0; lsu_AR_ADDR = '0; lsu_R_READY = 1'b0;
    wr_pending = 1'b0; axi_AR_READY = 1'b0; axi_R_VALID = 1'b0; axi_R_DATA = '0;
    d_pend = 1'b0; d_paddr = '0; d_delay = 0; d_arw = 0; d_iw = 0; d_lw = 0;
    forever begin
      @(negedge clk);
      d_rs  = rst_n;
      d_ih  = ifu_AR_VALID && ifu_AR_READY;
      d_lh  = lsu_AR_VALID && lsu_AR_READY;
      d_ah  = axi_AR_VALID && axi_AR_READY;
      d_rh  = axi_R_VALID && axi_R_READY;
      d_a   = axi_AR_ADDR;
      d_arw = (axi_AR_VALID && !axi_AR_READY) ? d_arw + 1 : 0;
      d_iw  = (ifu_R_VALID && !ifu_R_READY) ? d_iw + 1 : 0;
      d_lw  = (lsu_R_VALID && !lsu_R_READY) ? d_lw + 1 : 0;
      @(posedge clk);
      #1;
      if (d_rs) begin
        if (d_ih) ifu_AR_VALID = 1'b0;
        if (d_lh) lsu_AR_VALID = 1'b0;
        if (d_ah) begin
          d_pend  = 1'b1;
          d_paddr = d_a;
          d_delay = (fix_delay >= 0) ? fix_delay : (fast ? 0 : int'($urandom_range(0, 3)));
        end
        if (d_rh) begin
          axi_R_VALID = 1'b0;
          d_pend = 1'b0;
        end
      end else begin
        d_pend = 1'b0;
        axi_R_VALID = 1'b0;
      end
      if (!ifu_AR_VALID && ifu_issued < ifu_limit && int'($urandom_range(0, 3)) < ifu_rate) begin
        ifu_AR_VALID = 1'b1;
        ifu_AR_ADDR  = ifu_fix ? 64'h0000_0000_8000_0000 : {$urandom, $urandom};
        ifu_issued++;
      end
      if (!lsu_AR_VALID && lsu_issued < lsu_limit && int'($urandom_range(0, 3)) < lsu_rate) begin
        lsu_AR_VALID = 1'b1;
        lsu_AR_ADDR  = {$urandom, $urandom};
        lsu_issued++;
      end
      if (d_pend && !axi_R_VALID && !mute) begin
        if (d_delay == 0) begin
          axi_R_VALID = 1'b1;
          axi_R_DATA  = mem_data(d_paddr);
        end else begin
          d_delay--;
        end
      end
      axi_AR_READY = fast || d_arw >= 2 || $urandom_range(0, 1) == 1;
      ifu_R_READY  = fast || d_iw >= 2 || $urandom_range(0, 1) == 1;
      lsu_R_READY  = fast || d_lw >= 2 || $urandom_range(0, 1) == 1;
      wr_pending   = (wp_mode == 1) || (wp_mode == 0 && $urandom_range(0, 2) == 0);
    end
  end

  // Transaction-level reference: owner (0 none, 1 IFU, 2 LSU), address/data phase, age, sticky error
  int m_own = 0, m_last = 2, m_age = 0;
  bit m_data = 1'b0, m_err = 1'b0;
  bit m_rqi, m_rql, m_own_v, m_own_rr, m_in_addr, m_in_dat;
  logic [63:0] m_own_a;
  logic [1:0]  m_egrant;
  logic [63:0] ifu_exp[$], lsu_exp[$];
  int glog[$];
  int ifu_beats = 0, lsu_beats = 0;
  logic [63:0] ifu_last_data = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      m_egrant  = (m_own == 1) ? 2'b01 : ((m_own == 2) ? 2'b10 : 2'b00);
      m_own_v   = (m_own == 1) ? ifu_AR_VALID : lsu_AR_VALID;
      m_own_a   = (m_own == 1) ? ifu_AR_ADDR : lsu_AR_ADDR;
      m_own_rr  = (m_own == 1) ? ifu_R_READY : lsu_R_READY;
      m_in_addr = (m_own != 0) && !m_data;
      m_in_dat  = (m_own != 0) && m_data;
      chk("rd_grant", rd_grant, m_egrant);
      chk("timeout_err", timeout_err, m_err);
      chk("axi_AR_VALID", axi_AR_VALID, m_in_addr ? m_own_v : 1'b0);
      chk("axi_AR_ADDR", axi_AR_ADDR, m_in_addr ? m_own_a : 64'h0);
      chk("ifu_AR_READY", ifu_AR_READY, (m_in_addr && m_own == 1) ? axi_AR_READY : 1'b0);
      chk("lsu_AR_READY", lsu_AR_READY, (m_in_addr && m_own == 2) ? axi_AR_READY : 1'b0);
      chk("ifu_R_VALID", ifu_R_VALID, (m_in_dat && m_own == 1) ? axi_R_VALID : 1'b0);
      chk("lsu_R_VALID", lsu_R_VALID, (m_in_dat && m_own == 2) ? axi_R_VALID : 1'b0);
      chk("axi_R_READY", axi_R_READY, m_in_dat ? m_own_rr : 1'b0);
      if (!rst_n) begin
        m_own = 0; m_last = 2; m_age = 0; m_data = 1'b0; m_err = 1'b0;
        ifu_exp.delete(); lsu_exp.delete();
      end else begin
        if (ifu_AR_VALID && ifu_AR_READY) ifu_exp.push_back(mem_data(ifu_AR_ADDR));
        if (lsu_AR_VALID && lsu_AR_READY) lsu_exp.push_back(mem_data(lsu_AR_ADDR));
        if (ifu_R_VALID && ifu_R_READY) begin
          ifu_beats++;
          ifu_last_data = ifu_R_DATA;
          if (ifu_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL ifu_R_DATA unexpected beat actual=%0h required=none", ifu_R_DATA);
          end else chk("ifu_R_DATA", ifu_R_DATA, ifu_exp.pop_front());
        end
        if (lsu_R_VALID && lsu_R_READY) begin
          lsu_beats++;
          if (lsu_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL lsu_R_DATA unexpected beat actual=%0h required=none", lsu_R_DATA);
          end else chk("lsu_R_DATA", lsu_R_DATA, lsu_exp.pop_front());
        end
        if (m_own == 0) begin
          m_rqi = ifu_AR_VALID;
          m_rql = lsu_AR_VALID && !wr_pending;
          if (m_rqi || m_rql) begin
            m_own  = (m_rqi && m_rql) ? ((m_last == 1) ? 2 : 1) : (m_rqi ? 1 : 2);
            m_data = 1'b0;
            m_age  = 0;
            glog.push_back(m_own);
          end
        end else if (m_data && axi_R_VALID && m_own_rr) begin
          m_last = m_own;
          m_own  = 0;
        end else if (m_age == TO - 1) begin
          m_err = 1'b1;
          m_own = 0;
          ifu_exp.delete(); lsu_exp.delete();
        end else begin
          m_age++;
          if (!m_data && m_own_v && axi_AR_READY) m_data = 1'b1;
        end
      end
    end
  end

  function automatic int glog_at(input int i);
    if (i < glog.size()) return glog[i];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic stop_reqs();
    ifu_limit = ifu_issued;
    lsu_limit = lsu_issued;
  endtask

  int g0, b0, n;

  initial begin : sequencer
    rst_n = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    tick(1);
    rst_n = 1'b1;

    // Single IFU fetch with a fixed address and a two-cycle data gap
    g0 = glog.size(); b0 = lsu_beats;
    fast = 1'b1; fix_delay = 1; ifu_fix = 1'b1; ifu_rate = 4; ifu_limit = ifu_issued + 1;
    tick(12);
    chk("t1_grants", glog.size() - g0, 1);
    chk("t1_owner", glog_at(g0), 1);
    chk("t1_data", ifu_last_data, 64'h413);
    chk("t1_lsu_beats", lsu_beats - b0, 0);
    ifu_fix = 1'b0; fix_delay = -1;

    // Continuous contention right after reset alternates owners
    pulse_reset();
    g0 = glog.size();
    ifu_rate = 4; lsu_rate = 4; ifu_limit = ifu_issued + 2; lsu_limit = lsu_issued + 2;
    tick(30);
    chk("t2_order0", glog_at(g0), 1);
    chk("t2_order1", glog_at(g0 + 1), 2);
    chk("t2_order2", glog_at(g0 + 2), 1);
    chk("t2_order3", glog_at(g0 + 3), 2);

    // Pending write holds off the load until it clears
    g0 = glog.size();
    wp_mode = 1; ifu_limit = ifu_issued + 1; lsu_limit = lsu_issued + 1;
    tick(12);
    chk("t4_ifu_first", glog_at(g0), 1);
    chk("t4_lsu_blocked", glog.size() - g0, 1);
    wp_mode = 2;
    tick(12);
    chk("t4_lsu_next", glog_at(g0 + 1), 2);

    // Random traffic with back-pressure and random write-pending
    g0 = glog.size();
    fast = 1'b0; wp_mode = 0; ifu_rate = 2; lsu_rate = 2;
    ifu_limit = ifu_issued + 200; lsu_limit = lsu_issued + 200;
    tick(1500);
    stop_reqs();
    tick(40);
    chk("rand_progress", glog.size() - g0 > 60, 1'b1);
    chk("rand_ifu_drained", ifu_exp.size(), 0);
    chk("rand_lsu_drained", lsu_exp.size(), 0);

    // Slave accepts the address but never returns data
    pulse_reset();
    fast = 1'b1; mute = 1'b1; wp_mode = 2; ifu_rate = 4; ifu_limit = ifu_issued + 1;
    n = 0;
    while (rd_grant == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk("t5_granted", rd_grant, 2'b01);
    n = 0;
    while (!timeout_err && n < 40) begin @(negedge clk); n++; end
    chk("t5_latency", n, 16);
    chk("t5_grant_cleared", rd_grant, 2'b00);
    tick(10);
    @(negedge clk);
    chk("t5_sticky", timeout_err, 1'b1);
    tick(1);
    pulse_reset();
    @(negedge clk);
    chk("t5_cleared_by_reset", timeout_err, 1'b0);

    // Reset in the data phase drops the read; the next one completes
    ifu_limit = ifu_issued + 1;
    n = 0;
    while (rd_grant == 2'b00 && n < 20) begin @(negedge clk); n++; end
    tick(1);
    pulse_reset();
    @(negedge clk);
    chk("t6_grant", rd_grant, 2'b00);
    chk("t6_axi_R_READY", axi_R_READY, 1'b0);
    chk("t6_axi_AR_VALID", axi_AR_VALID, 1'b0);
    tick(1);
    mute = 1'b0; b0 = ifu_beats;
    ifu_limit = ifu_issued + 1;
    tick(15);
    chk("t6_after_reset", ifu_beats - b0, 1);

    n = 0;
    while (!p_done && n < 200) begin tick(1); n++; end
    chk("prio_done", p_done, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  int p_lsu_n = 0;

  initial begin : prio_test
    p_rst_n = 1'b0; p_wp = 1'b0;
    p_ifu_v = 1'b0; p_lsu_v = 1'b0; p_ifu_a = 64'h1000; p_lsu_a = 64'h2000;
    p_ifu_rr = 1'b1; p_lsu_rr = 1'b1;
    p_axi_ardy = 1'b1; p_axi_rv = 1'b1; p_axi_rd = 64'h55AA;
    repeat (2) @(posedge clk);
    #1;
    p_rst_n = 1'b1; p_ifu_v = 1'b1; p_lsu_v = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("p_ifu_AR_READY", p_ifu_ardy, 1'b0);
      chk("p_ifu_R_VALID", p_ifu_rv, 1'b0);
      chk("p_no_ifu_grant", p_grant[0], 1'b0);
      if (p_lsu_rv && p_lsu_rr) p_lsu_n++;
    end
    chk("p_lsu_beats", p_lsu_n, 4);
    @(posedge clk);
    #1 p_axi_rv = 1'b0;
    repeat (40) @(negedge clk);
    chk("p_wdog_disabled", p_err, 1'b0);
    chk("p_stuck_owner", p_grant, 2'b10);
    p_done = 1'b1;
  end

endmodule
